// File: rtl/tone_pwm_player.sv
// Note player: latches one note per valid/ready handshake, plays a phase-accumulator square wave as
// decaying-amplitude 1-bit PWM for note_len sample ticks; note_ready is low for the whole note (no queueing).
module tone_pwm_player #(
    parameter int CLK_DIV  = 128,
    parameter int LEN_BITS = 16,
    parameter int ENV_STEP = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [3:0]          note_id,
    input  logic [LEN_BITS-1:0] note_len,
    output logic                busy,
    output logic                note_done,
    output logic                pwm
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int ENV_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] AMP_MIN = DIV_W'(16);
    localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(ENV_STEP - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [15:0]          phase_q, phase_d;
    logic [15:0]          inc_q, inc_d;
    logic [DIV_W-1:0]     amp_q, amp_d;
    logic [ENV_W-1:0]     env_cnt_q, env_cnt_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;
    logic                 note_done_q, note_done_d;
    logic                 sample_tick, accept, start, finish;

    function automatic logic [15:0] inc_lut(input logic [3:0] id);
        case (id)
            4'd0:    inc_lut = 16'd88;
            4'd1:    inc_lut = 16'd99;
            4'd2:    inc_lut = 16'd111;
            4'd3:    inc_lut = 16'd117;
            4'd4:    inc_lut = 16'd132;
            4'd5:    inc_lut = 16'd148;
            4'd6:    inc_lut = 16'd166;
            4'd7:    inc_lut = 16'd176;
            4'd8:    inc_lut = 16'd197;
            4'd9:    inc_lut = 16'd221;
            4'd10:   inc_lut = 16'd234;
            4'd11:   inc_lut = 16'd263;
            default: inc_lut = 16'd0;
        endcase
    endfunction

    assign sample_tick = (div_cnt_q == DIV_MAX);
    assign accept      = note_valid && note_ready;
    assign start       = accept && (note_len != '0);
    assign finish      = (state_q == PLAY) && sample_tick && (remaining_q == LEN_BITS'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = PLAY;
            PLAY:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        note_ready = !rst && (state_q == IDLE);
        busy       = !rst && (state_q == PLAY);
        note_done  = !rst && note_done_q;
        pwm        = !rst && (state_q == PLAY) && (inc_q != 16'd0) && phase_q[15] && (div_cnt_q < amp_q);
    end

    // The divider free-runs across notes, so the first tick of a note lands anywhere in 1..CLK_DIV clocks.
    always_comb begin
        div_cnt_d   = sample_tick ? '0 : div_cnt_q + 1'b1;
        phase_d     = phase_q;
        inc_d       = inc_q;
        amp_d       = amp_q;
        env_cnt_d   = env_cnt_q;
        remaining_d = remaining_q;
        note_done_d = finish;
        if (start) begin
            remaining_d = note_len;
            phase_d     = 16'd0;
            amp_d       = DIV_MAX;
            env_cnt_d   = '0;
            inc_d       = inc_lut(note_id);
        end else if ((state_q == PLAY) && sample_tick) begin
            phase_d     = phase_q + inc_q;
            remaining_d = remaining_q - LEN_BITS'(1);
            if (env_cnt_q == ENV_MAX) begin
                env_cnt_d = '0;
                if (amp_q > AMP_MIN) amp_d = amp_q - 1'b1;
            end else begin
                env_cnt_d = env_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            phase_q     <= 16'd0;
            inc_q       <= 16'd0;
            amp_q       <= '0;
            env_cnt_q   <= '0;
            remaining_q <= '0;
            note_done_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            amp_q       <= amp_d;
            env_cnt_q   <= env_cnt_d;
            remaining_q <= remaining_d;
            note_done_q <= note_done_d;
        end
    end
endmodule
